// File: rtl/univ_shift_reg_n.sv
// Universal N-bit shift register: single-step operations via en, or multi-step
// bursts via start, with busy/done handshake and asynchronous active-high reset.
module univ_shift_reg_n #(
  parameter int WIDTH = 8,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic             en,
  input  logic             start,
  input  logic [SHW-1:0]   shamt,
  input  logic             serial_in_msb,
  input  logic             serial_in_lsb,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] q,
  output logic             serial_out_msb,
  output logic             serial_out_lsb,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  localparam logic [SHW-1:0] CNT_ZERO = '0;
  localparam logic [SHW-1:0] CNT_ONE  = SHW'(1'b1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic [SHW-1:0]   eff_cnt_s;

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic             sin_msb,
    input logic             sin_lsb,
    input logic [WIDTH-1:0] pin
  );
    case (op)
      MODE_HOLD: return cur;
      MODE_SHR:  return {sin_msb, cur[WIDTH-1:1]};
      MODE_SHL:  return {cur[WIDTH-2:0], sin_lsb};
      MODE_LOAD: return pin;
      MODE_ROR:  return {cur[0], cur[WIDTH-1:1]};
      MODE_ROL:  return {cur[WIDTH-2:0], cur[WIDTH-1]};
      MODE_ASR:  return {cur[WIDTH-1], cur[WIDTH-1:1]};
      MODE_CLR:  return '0;
      default:   return cur;
    endcase
  endfunction

  // Hold, load and clear are idempotent-ish one-shot ops, so a burst of them is one step
  always_comb begin
    case (mode)
      MODE_HOLD, MODE_LOAD, MODE_CLR: eff_cnt_s = CNT_ONE;
      default:                        eff_cnt_s = shamt;
    endcase
  end

  // Next-state: burst stepping takes precedence, then burst accept, then single step
  always_comb begin
    q_d    = q_q;
    busy_d = busy_q;
    done_d = 1'b0;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    if (busy_q) begin
      q_d   = apply_op(mode_q, q_q, serial_in_msb, serial_in_lsb, parallel_in);
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
      end
    end else if (start) begin
      mode_d = mode;
      cnt_d  = eff_cnt_s;
      if (eff_cnt_s == CNT_ZERO) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
      end
    end else if (en) begin
      q_d = apply_op(mode, q_q, serial_in_msb, serial_in_lsb, parallel_in);
    end else begin
      q_d = q_q;
    end
  end

  // State registers; reset aborts any burst without a trailing done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      mode_q <= MODE_HOLD;
    end else begin
      q_q    <= q_d;
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
    end
  end

  assign q              = q_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign serial_out_msb = q_q[WIDTH-1];
  assign serial_out_lsb = q_q[0];

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Self-checking bench for univ_shift_reg_n: directed scenarios plus randomized
// traffic compared against an arithmetic reference model with a pending-step queue.
module tb_univ_shift_reg_n;

  logic       clk, rst, en, start, sim, sil;
  logic [2:0] mode;
  logic [3:0] shamt;
  logic [7:0] pin, q;
  logic       som, sol, busy, done;

  int checks = 0;
  int errors = 0;

  univ_shift_reg_n #(.WIDTH(8), .SHW(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .en(en), .start(start), .shamt(shamt),
    .serial_in_msb(sim), .serial_in_lsb(sil), .parallel_in(pin), .q(q),
    .serial_out_msb(som), .serial_out_lsb(sol), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // Reference operation written as plain integer arithmetic on the value
  function automatic logic [7:0] ref_op(input logic [2:0] m, input logic [7:0] v,
                                        input logic si_m, input logic si_l,
                                        input logic [7:0] p);
    int x;
    int r;
    x = int'(v);
    case (m)
      3'd0: r = x;
      3'd1: r = x / 2 + (si_m ? 128 : 0);
      3'd2: r = (x * 2) % 256 + (si_l ? 1 : 0);
      3'd3: r = int'(p);
      3'd4: r = x / 2 + (x % 2) * 128;
      3'd5: r = (x * 2) % 256 + x / 128;
      3'd6: r = x / 2 + (x / 128) * 128;
      default: r = 0;
    endcase
    return 8'(r);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_value(input logic [7:0] v);
    mode = 3'b011; pin = v; en = 1'b1; start = 1'b0;
    cyc();
    en = 1'b0; mode = 3'b000;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; start = 1'b1; mode = 3'b011; shamt = 4'd5;
    sim = 1'b1; sil = 1'b1; pin = 8'hFF;
    #2;
    checks++;
    if ({busy, done, q} !== {1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_async: busy/done/q=%b/%b/%h want 0/0/00", busy, done, q);
    end
    cyc(); cyc();
    checks++;
    if ({busy, done, q} !== {1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_held: busy/done/q=%b/%b/%h want 0/0/00", busy, done, q);
    end
    rst = 1'b0; en = 1'b0; start = 1'b0; mode = 3'b000;
    cyc();
    checks++;
    if ({busy, done, q} !== {1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_release_idle: busy/done/q=%b/%b/%h want 0/0/00", busy, done, q);
    end
  endtask

  task automatic test_single_step();
    load_value(8'hA5);
    checks++;
    if (q !== 8'hA5) begin
      errors++;
      $display("FAIL single_load: q=%h want a5", q);
    end
    mode = 3'b001; sim = 1'b1; en = 1'b1;
    cyc();
    en = 1'b0; mode = 3'b000;
    checks++;
    if ({busy, done, q, som, sol} !== {1'b0, 1'b0, 8'hD2, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single_shr: busy/done/q/som/sol=%b/%b/%h/%b/%b want 0/0/d2/1/0",
               busy, done, q, som, sol);
    end
  endtask

  task automatic test_rotate_burst();
    logic [7:0] exp_q [3];
    exp_q[0] = 8'h03; exp_q[1] = 8'h06; exp_q[2] = 8'h0C;
    load_value(8'h81);
    start = 1'b1; mode = 3'b101; shamt = 4'd3;
    cyc();
    start = 1'b0; mode = 3'b000; shamt = 4'd0;
    checks++;
    if ({busy, done, q} !== {1'b1, 1'b0, 8'h81}) begin
      errors++;
      $display("FAIL rol_accept: busy/done/q=%b/%b/%h want 1/0/81", busy, done, q);
    end
    for (int i = 1; i <= 3; i++) begin
      cyc();
      checks++;
      if ({busy, done, q} !== {1'(i < 3), 1'(i == 3), exp_q[i-1]}) begin
        errors++;
        $display("FAIL rol_step%0d: busy/done/q=%b/%b/%h want %b/%b/%h", i, busy, done, q,
                 1'(i < 3), 1'(i == 3), exp_q[i-1]);
      end
    end
    cyc();
    checks++;
    if ({busy, done, q} !== {1'b0, 1'b0, 8'h0C}) begin
      errors++;
      $display("FAIL rol_after_done: busy/done/q=%b/%b/%h want 0/0/0c", busy, done, q);
    end
  endtask

  task automatic test_ashr();
    load_value(8'h90);
    start = 1'b1; mode = 3'b110; shamt = 4'd2;
    cyc();
    start = 1'b0;
    cyc();
    checks++;
    if ({busy, done, q} !== {1'b1, 1'b0, 8'hC8}) begin
      errors++;
      $display("FAIL asr_step1: busy/done/q=%b/%b/%h want 1/0/c8", busy, done, q);
    end
    cyc();
    checks++;
    if ({busy, done, q} !== {1'b0, 1'b1, 8'hE4}) begin
      errors++;
      $display("FAIL asr_step2: busy/done/q=%b/%b/%h want 0/1/e4", busy, done, q);
    end
    cyc();
    start = 1'b1; mode = 3'b110; shamt = 4'd0;
    cyc();
    start = 1'b0;
    checks++;
    if ({busy, done, q} !== {1'b0, 1'b1, 8'hE4}) begin
      errors++;
      $display("FAIL asr_zero_done: busy/done/q=%b/%b/%h want 0/1/e4", busy, done, q);
    end
    cyc();
    checks++;
    if ({busy, done, q} !== {1'b0, 1'b0, 8'hE4}) begin
      errors++;
      $display("FAIL asr_zero_after: busy/done/q=%b/%b/%h want 0/0/e4", busy, done, q);
    end
  endtask

  task automatic test_busy_mask();
    logic       sims [4];
    logic       ens  [4];
    logic       sts  [4];
    logic [2:0] mds  [4];
    logic [7:0] exp_q[4];
    sims = '{1'b1, 1'b0, 1'b1, 1'b0};
    ens  = '{1'b0, 1'b1, 1'b0, 1'b0};
    sts  = '{1'b0, 1'b1, 1'b1, 1'b0};
    mds  = '{3'b001, 3'b111, 3'b011, 3'b001};
    exp_q = '{8'h9E, 8'h4F, 8'hA7, 8'h53};
    load_value(8'h3C);
    start = 1'b1; mode = 3'b001; shamt = 4'd4; pin = 8'hFF;
    cyc();
    for (int i = 0; i < 4; i++) begin
      sim = sims[i]; en = ens[i]; start = sts[i]; mode = mds[i]; shamt = 4'd0;
      cyc();
      checks++;
      if ({busy, done, q} !== {1'(i < 3), 1'(i == 3), exp_q[i]}) begin
        errors++;
        $display("FAIL mask_step%0d: busy/done/q=%b/%b/%h want %b/%b/%h", i + 1, busy, done,
                 q, 1'(i < 3), 1'(i == 3), exp_q[i]);
      end
    end
    en = 1'b0; start = 1'b0; mode = 3'b000;
    cyc();
  endtask

  task automatic test_reset_mid_burst();
    load_value(8'h5A);
    start = 1'b1; mode = 3'b001; shamt = 4'd5; sim = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, q} !== {1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL midrst_async: busy/done/q=%b/%b/%h want 0/0/00", busy, done, q);
    end
    start = 1'b1; en = 1'b1; mode = 3'b011; pin = 8'h77;
    cyc();
    rst = 1'b0; start = 1'b0; en = 1'b0; mode = 3'b000;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if ({busy, done, q} !== {1'b0, 1'b0, 8'h00}) begin
        errors++;
        $display("FAIL midrst_quiet%0d: busy/done/q=%b/%b/%h want 0/0/00", i, busy, done, q);
      end
    end
    start = 1'b1; mode = 3'b011; shamt = 4'd9; pin = 8'hC3;
    cyc();
    start = 1'b0; pin = 8'h00;
    checks++;
    if ({busy, done, q} !== {1'b1, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL midrst_restart_acc: busy/done/q=%b/%b/%h want 1/0/00", busy, done, q);
    end
    pin = 8'hC3;
    cyc();
    checks++;
    if ({busy, done, q} !== {1'b0, 1'b1, 8'hC3}) begin
      errors++;
      $display("FAIL midrst_restart_done: busy/done/q=%b/%b/%h want 0/1/c3", busy, done, q);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [7:0] v, e;
    v = 8'($urandom);
    load_value(v);
    e = v;
    start = 1'b1; mode = 3'b101; shamt = 4'd3;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e = ref_op(3'b101, e, 1'b0, 1'b0, 8'h00);
      cyc();
    end
    checks++;
    if ({busy, done, q} !== {1'b0, 1'b1, e}) begin
      errors++;
      $display("FAIL b2b_first_done: busy/done/q=%b/%b/%h want 0/1/%h", busy, done, q, e);
    end
    start = 1'b1; mode = 3'b100; shamt = 4'd8;
    cyc();
    start = 1'b0; mode = 3'b000;
    checks++;
    if ({busy, done, q} !== {1'b1, 1'b0, e}) begin
      errors++;
      $display("FAIL b2b_accept: busy/done/q=%b/%b/%h want 1/0/%h", busy, done, q, e);
    end
    for (int i = 1; i <= 8; i++) begin
      cyc();
      checks++;
      if ({busy, done} !== {1'(i < 8), 1'(i == 8)}) begin
        errors++;
        $display("FAIL b2b_step%0d: busy/done=%b/%b want %b/%b", i, busy, done,
                 1'(i < 8), 1'(i == 8));
      end
    end
    checks++;
    if (q !== e) begin
      errors++;
      $display("FAIL b2b_ror8_restore: q=%h want %h", q, e);
    end
    cyc();
  endtask

  // Randomized traffic: the model expands each accepted burst into a queue of steps
  task automatic test_random();
    logic [2:0] pend[$];
    logic [7:0] mq;
    logic       exp_done, do_rst;
    int         n;
    rst = 1'b1; en = 1'b0; start = 1'b0;
    cyc();
    rst = 1'b0;
    mq = 8'h00;
    pend.delete();
    for (int c = 0; c < 600; c++) begin
      do_rst = ($urandom_range(0, 59) == 0);
      en     = 1'($urandom_range(0, 1));
      start  = ($urandom_range(0, 4) == 0);
      mode   = 3'($urandom);
      shamt  = 4'($urandom);
      sim    = 1'($urandom);
      sil    = 1'($urandom);
      pin    = 8'($urandom);
      if (do_rst) begin
        mq = 8'h00;
        pend.delete();
        exp_done = 1'b0;
      end else if (pend.size() != 0) begin
        mq = ref_op(pend.pop_front(), mq, sim, sil, pin);
        exp_done = (pend.size() == 0);
      end else if (start) begin
        n = (mode == 3'd0 || mode == 3'd3 || mode == 3'd7) ? 1 : int'(shamt);
        exp_done = (n == 0);
        for (int k = 0; k < n; k++) pend.push_back(mode);
      end else begin
        if (en) mq = ref_op(mode, mq, sim, sil, pin);
        exp_done = 1'b0;
      end
      rst = do_rst;
      cyc();
      checks++;
      if ({busy, done, q, som, sol} !== {1'(pend.size() != 0), exp_done, mq, mq[7], mq[0]})
      begin
        errors++;
        $display("FAIL rand_cyc%0d: busy/done/q/som/sol=%b/%b/%h/%b/%b want %b/%b/%h/%b/%b",
                 c, busy, done, q, som, sol, 1'(pend.size() != 0), exp_done, mq, mq[7], mq[0]);
      end
      rst = 1'b0;
    end
    en = 1'b0; start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_rotate_burst();
    test_ashr();
    test_busy_mask();
    test_reset_mid_burst();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg_n.md
UNIV_SHIFT_REG_N -- requirements
Module: univ_shift_reg_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8: register width in bits, minimum 2.
REQ-002 SHALL have parameter SHW, default 4: width of shamt, with 2**SHW-1 >= WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port mode, input, 3 bits: operation select (REQ-012).
REQ-006 SHALL have port en, input, 1 bit: single-step enable.
REQ-007 SHALL have port start, input, 1 bit: multi-step burst request.
REQ-008 SHALL have port shamt, input, SHW bits: burst step count.
REQ-009 SHALL have ports serial_in_msb and serial_in_lsb, input, 1 bit each: fill bits for right and left shifts.
REQ-010 SHALL have port parallel_in, input, WIDTH bits: load data.
REQ-011 SHALL have outputs q (WIDTH bits, register contents), serial_out_msb (= q[WIDTH-1]), serial_out_lsb (= q[0]), busy (1 bit) and done (1 bit).

Function
REQ-012 SHALL decode one operation per mode value:
- 000 hold
- 001 shift right, MSB <= serial_in_msb
- 010 shift left, LSB <= serial_in_lsb
- 011 load parallel_in
- 100 rotate right
- 101 rotate left
- 110 arithmetic shift right, MSB replicated
- 111 clear to 0
REQ-013 SHALL, when idle (busy=0) with en=1 and start=0, apply the mode operation once at that edge; done stays 0.
REQ-014 SHALL, when idle with start=1, accept a burst at that edge: latch mode, load the step counter, and leave q unchanged; start SHALL take priority over en.
REQ-015 SHALL set the effective step count to 1 for latched modes 000, 011 and 111, and to shamt for all other modes.
REQ-016 SHALL, on acceptance with effective count 0, keep busy=0, leave q unchanged, and pulse done for the following cycle.
REQ-017 SHALL, on acceptance with effective count N>=1, assert busy, then on each of the next N edges apply the latched operation once and decrement the counter.
- Serial inputs and parallel_in are sampled live at each step edge.
- On the Nth step edge, busy SHALL drop to 0 and done SHALL go high for exactly one cycle.
REQ-018 SHALL complete an accepted burst in N+1 rising edges from the accept edge to the final step edge.
REQ-019 SHALL ignore start, en, mode and shamt changes while busy=1, except for the live sampling in REQ-017.
REQ-020 SHALL accept a new start in the cycle where done=1, because busy=0 in that cycle; back-to-back bursts are legal.
REQ-021 SHALL allow shamt >= WIDTH: the operation simply repeats, so shift right by WIDTH fills q entirely with sampled serial_in_msb values and rotate by WIDTH restores the original q.
REQ-022 SHALL drive serial_out_msb and serial_out_lsb combinationally from q.

Reset
REQ-023 SHALL, while rst=1, force q=0, busy=0, done=0 and step counter=0, independent of clk.
REQ-024 SHALL abort any burst in progress on reset assertion; no done pulse follows the aborted burst.
REQ-025 SHALL accept no en or start at an edge where rst=1; operation resumes at the first rising edge after rst falls.

Verification
REQ-026 Single step: WIDTH=8; load 8'hA5 via en with mode=011, then en with mode=001 and serial_in_msb=1 -> q=8'hD2.
REQ-027 Rotate burst: q=8'h81; start with mode=101 and shamt=3 -> busy high for 3 cycles, q=8'h0C, one-cycle done pulse.
REQ-028 Arithmetic shift: q=8'h90; start with mode=110 and shamt=2 -> q=8'hE4; then shamt=0 -> done pulse next cycle, busy never high, q unchanged.
REQ-029 Busy masking: during a mode=001, shamt=4 burst, pulse en with mode=111 and start -> both ignored; final q is the 4-step right shift result.
REQ-030 Reset mid-burst: assert rst after 2 of 5 steps -> q=8'h00, busy=0, no done pulse; a new start after rst falls is accepted.
REQ-031 Back-to-back: start in the done cycle with mode=100 and shamt=8 -> q after 8 steps equals q at accept.
